cp0_intr_ctrl: RTL

Coprocessor-0 register file and interrupt controller feeding the ISR instruction ROM stage. Holds Count, Compare, Status, Cause and EPC, serves mfc0/mtc0 accesses, raises the timer interrupt and gates external IRQs. On an accepted interrupt it captures the return PC, masks further interrupts and drives isr_active so fetch selects the ISR ROM until the handler's return.

---
 rtl/cp0_intr_ctrl_if.sv | 23 ++
 rtl/cp0_intr_ctrl.sv | 127 ++++++++++++
 2 files changed

// File: rtl/cp0_intr_ctrl_if.sv
// Core-side bus of the CP0 block: mfc0/mtc0 access, interrupt handshake
// and ISR fetch select. The core is the master, cp0_intr_ctrl the slave.
interface cp0_intr_ctrl_if;
    logic [4:0]  cp0_addr;
    logic        cp0_we;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] epc_in;
    logic        intr_ack;
    logic        isr_exit;
    logic        intr_req;
    logic        isr_active;

    modport master (
        output cp0_addr, cp0_we, cp0_wdata, epc_in, intr_ack, isr_exit,
        input  cp0_rdata, intr_req, isr_active
    );

    modport slave (
        input  cp0_addr, cp0_we, cp0_wdata, epc_in, intr_ack, isr_exit,
        output cp0_rdata, intr_req, isr_active
    );
endinterface

// File: rtl/cp0_intr_ctrl.sv
// Coprocessor-0 register file (Count/Compare/Status/Cause/EPC) with timer
// interrupt, external IRQ synchronisers and ISR-ROM fetch select.
//
// state  | meaning
// ST_RUN | normal fetch, interrupts may be accepted
// ST_ISR | handler running from ISR ROM until isr_exit
module cp0_intr_ctrl #(
    parameter int unsigned COUNT_DIV   = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [4:0]     ext_irq,
    cp0_intr_ctrl_if.slave cp0
);

    localparam logic [4:0]  A_COUNT   = 5'd9;
    localparam logic [4:0]  A_COMPARE = 5'd11;
    localparam logic [4:0]  A_STATUS  = 5'd12;
    localparam logic [4:0]  A_CAUSE   = 5'd13;
    localparam logic [4:0]  A_EPC     = 5'd14;
    localparam logic [15:0] PRESC_MAX = 16'(COUNT_DIV - 1);

    typedef enum logic {ST_RUN, ST_ISR} isr_state_t;

    isr_state_t                  state_q;
    logic [15:0]                 presc_q;
    logic [31:0]                 count_q;
    logic [31:0]                 compare_q;
    logic [7:0]                  im_q;
    logic                        ie_q;
    logic                        ip7_q;
    logic [1:0]                  ip_sw_q;
    logic [31:0]                 epc_q;
    logic [SYNC_STAGES-1:0][4:0] sync_q;
    logic                        intr_req_q;

    logic       tick;
    logic       ack_ok;
    logic       wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic [7:0] cause_ip;

    assign tick       = (presc_q == PRESC_MAX);
    assign ack_ok     = cp0.intr_ack && intr_req_q;
    assign wr_count   = cp0.cp0_we && (cp0.cp0_addr == A_COUNT);
    assign wr_compare = cp0.cp0_we && (cp0.cp0_addr == A_COMPARE);
    assign wr_status  = cp0.cp0_we && (cp0.cp0_addr == A_STATUS);
    assign wr_cause   = cp0.cp0_we && (cp0.cp0_addr == A_CAUSE);
    assign wr_epc     = cp0.cp0_we && (cp0.cp0_addr == A_EPC);
    // IP6..IP2 come straight from the last synchroniser stage (level, not latched)
    assign cause_ip   = {ip7_q, sync_q[SYNC_STAGES-1], ip_sw_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            presc_q    <= '0;
            count_q    <= '0;
            compare_q  <= '1;
            im_q       <= '0;
            ie_q       <= 1'b0;
            ip7_q      <= 1'b0;
            ip_sw_q    <= '0;
            epc_q      <= '0;
            sync_q     <= '0;
            intr_req_q <= 1'b0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 16'd1;

            if (wr_count)
                count_q <= cp0.cp0_wdata;
            else if (tick)
                count_q <= count_q + 32'd1;

            if (wr_compare)
                compare_q <= cp0.cp0_wdata;

            // Compare write acknowledges the timer and beats a same-edge match
            if (wr_compare)
                ip7_q <= 1'b0;
            else if (tick && (count_q == compare_q))
                ip7_q <= 1'b1;

            if (wr_status)
                im_q <= cp0.cp0_wdata[15:8];

            if (ack_ok)
                ie_q <= 1'b0;
            else if (wr_status)
                ie_q <= cp0.cp0_wdata[0];

            if (wr_cause)
                ip_sw_q <= cp0.cp0_wdata[9:8];

            if (ack_ok)
                epc_q <= cp0.epc_in;
            else if (wr_epc)
                epc_q <= cp0.cp0_wdata;

            sync_q <= {sync_q[SYNC_STAGES-2:0], ext_irq};

            intr_req_q <= ack_ok ? 1'b0 : (ie_q && |(im_q & cause_ip));

            // A coincident exit and ack is a back-to-back entry: stay in ISR
            case (state_q)
                ST_RUN:  if (ack_ok) state_q <= ST_ISR;
                ST_ISR:  if (cp0.isr_exit && !ack_ok) state_q <= ST_RUN;
                default: state_q <= ST_RUN;
            endcase
        end
    end

    always_comb begin
        cp0.cp0_rdata = '0;
        case (cp0.cp0_addr)
            A_COUNT:   cp0.cp0_rdata = count_q;
            A_COMPARE: cp0.cp0_rdata = compare_q;
            A_STATUS:  cp0.cp0_rdata = {16'd0, im_q, 7'd0, ie_q};
            A_CAUSE:   cp0.cp0_rdata = {16'd0, cause_ip, 8'd0};
            A_EPC:     cp0.cp0_rdata = epc_q;
            default:   cp0.cp0_rdata = '0;
        endcase
    end

    assign cp0.intr_req   = intr_req_q;
    assign cp0.isr_active = (state_q == ST_ISR);

endmodule
